// File: rtl/rec_tq_perm_pipe_if.sv
// Row bus for the rec_tq coefficient-reorder stage.
// One instance carries rows into the stage, another carries them out.
//   vld/rdy   : valid/ready handshake; a row moves when both are high
//   transize  : transform size tag, N = 4 << transize
//   dir       : 0 forward interleave, 1 inverse
//   last/err  : block framing tags (meaningful on the output side only)
//   dat       : LANES coefficients of DW bits, lane k = dat[k*DW +: DW]
interface rec_tq_perm_pipe_if #(
  parameter int unsigned DW    = 28,
  parameter int unsigned LANES = 32
);
  logic                  vld;
  logic                  rdy;
  logic [1:0]            transize;
  logic                  dir;
  logic                  last;
  logic                  err;
  logic [LANES*DW-1:0]   dat;

  modport master (output vld, transize, dir, last, err, dat, input rdy);
  modport slave  (input vld, transize, dir, last, err, dat, output rdy);
endinterface

// File: rtl/rec_tq_perm_pipe.sv
// Registered coefficient-reorder stage between transform butterfly passes.
// Applies the size-dependent even/odd interleave permutation to one row of
// LANES coefficients per beat, with a one-entry skid buffer so a full row per
// clock is sustained under backpressure. Rows are framed into blocks of N rows;
// the last row of each block and size-consistency errors are tagged.
//
// Optional feature macro: REC_TQ_PERM_INV_EN
//   defined     : in_bus.dir selects forward/inverse per row
//   not defined : forward only, in_bus.dir ignored, out_bus.dir is 0
//
// Ports
//   clk     : clock
//   rstn    : asynchronous active-low reset
//   in_bus  : incoming rows (slave): vld, rdy, transize, dir, dat
//   out_bus : permuted rows (master): vld, rdy, transize, dir, last, err, dat
module rec_tq_perm_pipe #(
  parameter int unsigned DW    = 28,
  parameter int unsigned LANES = 32
) (
  input  logic               clk,
  input  logic               rstn,
  rec_tq_perm_pipe_if.slave  in_bus,
  rec_tq_perm_pipe_if.master out_bus
);

  localparam int unsigned RW = LANES * DW;

  typedef struct packed {
    logic [1:0]    ts;
    logic          dir;
    logic          last;
    logic          err;
    logic [RW-1:0] dat;
  } row_t;

  // Source position of output index j in an N-wide group: P_N(j).
  // Even indices recurse into the half-size permutation; the first odd index
  // reached maps into the upper half of the current sub-size.
  function automatic int unsigned perm_idx(input int unsigned n, input int unsigned j);
    int unsigned nn;
    int unsigned jj;
    nn = n;
    jj = j;
    for (int i = 0; i < 4; i++) begin
      if (nn > 4 && (jj % 2) == 0) begin
        jj = jj / 2;
        nn = nn / 2;
      end
    end
    if (nn > 4) return nn / 2 + jj / 2;
    return jj;
  endfunction

`ifdef REC_TQ_PERM_INV_EN
  // Inverse of P_N: the j' with P_N(j') == j.
  function automatic int unsigned inv_idx(input int unsigned n, input int unsigned j);
    int unsigned r;
    r = 0;
    for (int unsigned t = 0; t < n; t++) begin
      if (perm_idx(n, t) == j) r = t;
    end
    return r;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Permutation networks, one per transform size (pure wiring)
  // ---------------------------------------------------------------------------
  logic [RW-1:0] fwd_row [4];
`ifdef REC_TQ_PERM_INV_EN
  logic [RW-1:0] inv_row [4];
`endif

  for (genvar s = 0; s < 4; s++) begin : g_size
    localparam int unsigned N = 4 << s;
    if (N <= LANES) begin : g_perm
      for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int unsigned Base = (k / N) * N;
        localparam int unsigned J    = k % N;
        localparam int unsigned Src  = Base + perm_idx(N, J);
        assign fwd_row[s][k*DW +: DW] = in_bus.dat[Src*DW +: DW];
`ifdef REC_TQ_PERM_INV_EN
        localparam int unsigned ISrc = Base + inv_idx(N, J);
        assign inv_row[s][k*DW +: DW] = in_bus.dat[ISrc*DW +: DW];
`endif
      end
    end else begin : g_pass
      // Block wider than the row: pass through untouched, flagged as error.
      assign fwd_row[s] = in_bus.dat;
`ifdef REC_TQ_PERM_INV_EN
      assign inv_row[s] = in_bus.dat;
`endif
    end
  end

  logic [RW-1:0] perm_row;
  always_comb begin
    perm_row = fwd_row[in_bus.transize];
`ifdef REC_TQ_PERM_INV_EN
    if (in_bus.dir) perm_row = inv_row[in_bus.transize];
`endif
  end

  // The input-side framing tags are never driven by upstream.
  logic unused_in;
`ifdef REC_TQ_PERM_INV_EN
  assign unused_in = in_bus.last ^ in_bus.err;
`else
  assign unused_in = in_bus.last ^ in_bus.err ^ in_bus.dir;
`endif

  // ---------------------------------------------------------------------------
  // Handshake and storage
  // ---------------------------------------------------------------------------
  logic out_vld_q, out_vld_d;
  logic skid_vld_q, skid_vld_d;
  row_t out_q, out_d;
  row_t skid_q, skid_d;
  row_t new_row;
  logic accept;
  logic out_fire;

  assign in_bus.rdy = ~skid_vld_q;
  assign accept     = in_bus.vld & ~skid_vld_q;
  assign out_fire   = out_vld_q & out_bus.rdy;

  // ---------------------------------------------------------------------------
  // Block framing: advances on accept only, independent of backpressure
  // ---------------------------------------------------------------------------
  logic [5:0] cnt_q, cnt_d, cnt_eff;
  logic [1:0] blk_q, blk_d;
  logic [6:0] n_rows;
  logic       mismatch;
  logic       tag_last;
  logic       tag_err;

  always_comb begin
    n_rows   = 7'd4 << in_bus.transize;
    mismatch = (cnt_q != 6'd0) && (in_bus.transize != blk_q);
    // A size change restarts framing: this row is row 0 of a new block.
    cnt_eff  = mismatch ? 6'd0 : cnt_q;
    tag_last = ({1'b0, cnt_eff} == (n_rows - 7'd1));
    tag_err  = mismatch | (n_rows > 7'(LANES));
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    if (accept) begin
      cnt_d = tag_last ? 6'd0 : cnt_eff + 6'd1;
      if (cnt_q == 6'd0 || mismatch) blk_d = in_bus.transize;
    end
  end

  always_comb begin
    new_row.ts   = in_bus.transize;
`ifdef REC_TQ_PERM_INV_EN
    new_row.dir  = in_bus.dir;
`else
    new_row.dir  = 1'b0;
`endif
    new_row.last = tag_last;
    new_row.err  = tag_err;
    new_row.dat  = perm_row;
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    out_d      = out_q;
    skid_d     = skid_q;
    if (skid_vld_q) begin
      // Skid full means input is stalled; only draining can happen.
      if (out_fire) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_vld_q || out_bus.rdy) begin
        out_d     = new_row;
        out_vld_d = 1'b1;
      end else begin
        skid_d     = new_row;
        skid_vld_d = 1'b1;
      end
    end else if (out_fire) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
      cnt_q      <= 6'd0;
      blk_q      <= 2'd0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      cnt_q      <= cnt_d;
      blk_q      <= blk_d;
    end
  end

  assign out_bus.vld      = out_vld_q;
  assign out_bus.transize = out_q.ts;
  assign out_bus.dir      = out_q.dir;
  assign out_bus.last     = out_q.last;
  assign out_bus.err      = out_q.err;
  assign out_bus.dat      = out_q.dat;

endmodule
